intersection_ctrl: RTL
======================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, giving clk cycles per tick; legal range >=1.
REQ-002 SHALL have parameter GREEN_TICKS, default 5, giving the green duration in ticks per direction.
REQ-003 SHALL have parameter YELLOW_TICKS, default 3, giving the yellow duration in ticks.
REQ-004 SHALL have parameter ALLRED_TICKS, default 1, giving the all-red clearance duration in ticks.
REQ-005 SHALL have parameter WALK_TICKS, default 4, giving the pedestrian walk duration in ticks.
REQ-006 SHALL have parameter CNT_W, default 34, giving the width of the prescaler and tick counters.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port ped_req, input, 1 bit: pedestrian request, sampled every clk.
REQ-010 SHALL have port flash_en, input, 1 bit: selects flash mode when high.
REQ-011 SHALL have ports ns_red, ns_yellow and ns_green, output, 1 bit each: north-south lamps.
REQ-012 SHALL have ports ew_red, ew_yellow and ew_green, output, 1 bit each: east-west lamps.
REQ-013 SHALL have port walk, output, 1 bit: pedestrian walk lamp.
REQ-014 SHALL have port ped_pending, output, 1 bit: latched, unserviced pedestrian request.
REQ-015 SHALL have port phase, output, 3 bits: current state encoding.

Function
REQ-016 SHALL encode states as 0 NS_GREEN, 1 NS_YELLOW, 2 ALL_RED_1, 3 EW_GREEN, 4 EW_YELLOW, 5 ALL_RED_2, 6 WALK, 7 FLASH.
REQ-017 SHALL decode all lamp outputs and phase from registered state only; no combinational path from inputs to outputs.
REQ-018 SHALL clear the prescaler and tick counter on every state change, so that a state of duration N lasts exactly N*TICK_DIV clk cycles.
REQ-019 SHALL treat any duration parameter equal to 0 as 1.
REQ-020 SHALL sequence normal states as NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> NS_GREEN.
REQ-021 SHALL, when ALL_RED_2 expires with ped_pending=1, enter WALK instead of NS_GREEN, and go from WALK to NS_GREEN after WALK_TICKS.
REQ-022 SHALL drive lamps per state, with exactly one lamp per direction lit in every non-FLASH state:
- NS_GREEN: ns_green and ew_red.
- NS_YELLOW: ns_yellow and ew_red.
- EW_GREEN: ns_red and ew_green.
- EW_YELLOW: ns_red and ew_yellow.
- ALL_RED_1, ALL_RED_2: ns_red and ew_red.
- WALK: ns_red, ew_red and walk.
REQ-023 SHALL set ped_pending on any cycle with ped_req=1 and clear it on the cycle WALK is entered; a set in the same cycle wins over the clear.
REQ-024 SHALL ignore ped_req pulses while in WALK except to set ped_pending for the next cycle.
REQ-025 SHALL enter FLASH on the cycle after flash_en is sampled high, from any state, discarding remaining state time.
REQ-026 SHALL, in FLASH, keep a flash bit that is 1 on entry and toggles every TICK_DIV cycles; ns_yellow and ew_red equal the flash bit, and all other lamps and walk are 0.
REQ-027 SHALL preserve ped_pending through FLASH.
REQ-028 SHALL, on the cycle after flash_en is sampled low while in FLASH, enter ALL_RED_2 with cleared counters.

Reset
REQ-029 SHALL, while rst is high, hold state ALL_RED_2 with cleared counters, flash bit 0 and ped_pending 0.
REQ-030 SHALL, while rst is high, drive ns_red=1, ew_red=1, all other lamps 0, walk=0 and phase=5.
REQ-031 SHALL take effect immediately on a rst assertion mid-state, including in WALK or FLASH, without waiting for a clock edge.

Verification
Bench parameters for all scenarios: TICK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1, WALK=2.
REQ-032 SHALL verify: release rst with no requests -> phase 5 for 4 cycles, then a repeating 48-cycle period of 0(12), 1(8), 2(4), 3(12), 4(8), 5(4).
REQ-033 SHALL verify: one-cycle ped_req during NS_GREEN -> ped_pending=1 until WALK entry; after ALL_RED_2, phase 6 with walk=1 for 8 cycles, then phase 0 with ped_pending=0.
REQ-034 SHALL verify: ped_req held high across WALK entry -> ped_pending stays 1, and a second WALK follows the next ALL_RED_2.
REQ-035 SHALL verify: flash_en raised mid EW_GREEN -> phase 7 next cycle with ns_yellow=ew_red=1 for 4 cycles, then 0 for 4 cycles, repeating; flash_en lowered -> phase 5 next cycle, then phase 0 after 4 cycles.
REQ-036 SHALL verify: rst asserted mid WALK with ped_pending=1 -> outputs immediately show all-red, walk=0, ped_pending=0, phase=5.
REQ-037 SHALL verify: with any lamp-phase sampling across all scenarios -> never more than one lamp lit per direction, and never both greens lit.

Source files
------------

// File: rtl/intersection_ctrl.sv
// -----------------------------------------------------------------------------
// intersection_ctrl
//
// Purpose:
//    Four-way traffic light controller with a pedestrian walk phase and a
//    flashing-yellow fallback mode. Every state lasts an integer number of
//    ticks, and a prescaler divides clk down to the tick rate. All outputs are
//    decoded from registered state, so nothing combinational leaks from the
//    inputs to the lamps.
//
// Parameters:
//    TICK_DIV      clk cycles per tick (>= 1)
//    GREEN_TICKS   green duration per direction, in ticks
//    YELLOW_TICKS  yellow duration, in ticks
//    ALLRED_TICKS  all-red clearance duration, in ticks
//    WALK_TICKS    pedestrian walk duration, in ticks
//    CNT_W         width of the prescaler and tick counters
//    A duration of 0 is treated as 1.
//
// Ports:
//    clk           single clock, rising edge
//    rst           asynchronous active-high reset
//    ped_req       pedestrian request, sampled every clk
//    flash_en      high selects flash mode
//    ns_red/ns_yellow/ns_green   north-south lamps
//    ew_red/ew_yellow/ew_green   east-west lamps
//    walk          pedestrian walk lamp
//    ped_pending   latched pedestrian request not yet serviced
//    phase         current state encoding (0..7)
// -----------------------------------------------------------------------------
module intersection_ctrl #(
   parameter int unsigned TICK_DIV     = 100_000_000,
   parameter int unsigned GREEN_TICKS  = 5,
   parameter int unsigned YELLOW_TICKS = 3,
   parameter int unsigned ALLRED_TICKS = 1,
   parameter int unsigned WALK_TICKS   = 4,
   parameter int          CNT_W        = 34
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5,
      WALK      = 3'd6,
      FLASH     = 3'd7
   } state_t;

   // Zero-length durations are promoted to one tick, and each duration is
   // stored as "last tick index" so expiry is a simple equality compare.
   localparam int unsigned DIV_EFF    = (TICK_DIV == 0)     ? 1 : TICK_DIV;
   localparam int unsigned GREEN_EFF  = (GREEN_TICKS == 0)  ? 1 : GREEN_TICKS;
   localparam int unsigned YELLOW_EFF = (YELLOW_TICKS == 0) ? 1 : YELLOW_TICKS;
   localparam int unsigned ALLRED_EFF = (ALLRED_TICKS == 0) ? 1 : ALLRED_TICKS;
   localparam int unsigned WALK_EFF   = (WALK_TICKS == 0)   ? 1 : WALK_TICKS;

   localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV_EFF - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_EFF - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_EFF - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_EFF - 1);
   localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_EFF - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] presc;
   logic [CNT_W-1:0] ticks;
   logic [CNT_W-1:0] dur_last;
   logic             tick_end;
   logic             walk_entry;
   logic             flash_bit;

   assign tick_end   = (presc == DIV_LAST);
   assign walk_entry = (state_next == WALK) && (state != WALK);

   // Next-state logic. flash_en overrides everything, including the remaining
   // time of the current state. Leaving FLASH always goes through ALL_RED_2 so
   // the intersection gets a clearance interval before traffic resumes. In
   // normal operation a state only advances when the last prescaler cycle of
   // its last tick is reached; ALL_RED_2 diverts to WALK when a pedestrian
   // request is waiting.
   always_comb begin
      state_next = state;
      dur_last   = ALLRED_LAST;
      case (state)
         NS_GREEN, EW_GREEN:   dur_last = GREEN_LAST;
         NS_YELLOW, EW_YELLOW: dur_last = YELLOW_LAST;
         WALK:                 dur_last = WALK_LAST;
         default:              dur_last = ALLRED_LAST;
      endcase
      if (flash_en) begin
         state_next = FLASH;
      end else if (state == FLASH) begin
         state_next = ALL_RED_2;
      end else if (tick_end && (ticks == dur_last)) begin
         case (state)
            NS_GREEN:  state_next = NS_YELLOW;
            NS_YELLOW: state_next = ALL_RED_1;
            ALL_RED_1: state_next = EW_GREEN;
            EW_GREEN:  state_next = EW_YELLOW;
            EW_YELLOW: state_next = ALL_RED_2;
            ALL_RED_2: state_next = ped_pending ? WALK : NS_GREEN;
            WALK:      state_next = NS_GREEN;
            default:   state_next = ALL_RED_2;
         endcase
      end
   end

   // State register. Reset parks the controller in ALL_RED_2 so that the
   // first thing seen after reset is a full clearance interval.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ALL_RED_2;
      end else begin
         state <= state_next;
      end
   end

   // Prescaler and tick counter. Both restart on every state change so each
   // state lasts exactly its tick count times TICK_DIV cycles. In FLASH only
   // the prescaler matters (it paces the blink), so the tick counter is held
   // there rather than left to run unbounded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         ticks <= '0;
      end else if (state_next != state) begin
         presc <= '0;
         ticks <= '0;
      end else if (tick_end) begin
         presc <= '0;
         if (state != FLASH) begin
            ticks <= ticks + CNT_W'(1);
         end
      end else begin
         presc <= presc + CNT_W'(1);
      end
   end

   // Blink phase for flash mode. It starts lit on entry and inverts at the
   // end of every tick while FLASH persists; outside FLASH it rests at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flash_bit <= 1'b0;
      end else if (state_next != FLASH) begin
         flash_bit <= 1'b0;
      end else if (state != FLASH) begin
         flash_bit <= 1'b1;
      end else if (tick_end) begin
         flash_bit <= ~flash_bit;
      end
   end

   // Pedestrian request latch. Any cycle with ped_req sets it; the cycle that
   // enters WALK clears it, but a request arriving on that same cycle wins so
   // it is served by the next WALK. FLASH neither sets nor clears it beyond
   // that, so requests survive a flash episode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ped_pending <= 1'b0;
      end else begin
         ped_pending <= ped_req | (ped_pending & ~walk_entry);
      end
   end

   // Output decode from registered state only. Every non-FLASH state lights
   // exactly one lamp per direction; FLASH shows blinking yellow on NS and
   // blinking red on EW in unison.
   always_comb begin
      ns_red    = 1'b0;
      ns_yellow = 1'b0;
      ns_green  = 1'b0;
      ew_red    = 1'b0;
      ew_yellow = 1'b0;
      ew_green  = 1'b0;
      walk      = 1'b0;
      phase     = state;
      case (state)
         NS_GREEN: begin
            ns_green = 1'b1;
            ew_red   = 1'b1;
         end
         NS_YELLOW: begin
            ns_yellow = 1'b1;
            ew_red    = 1'b1;
         end
         EW_GREEN: begin
            ns_red   = 1'b1;
            ew_green = 1'b1;
         end
         EW_YELLOW: begin
            ns_red    = 1'b1;
            ew_yellow = 1'b1;
         end
         WALK: begin
            ns_red = 1'b1;
            ew_red = 1'b1;
            walk   = 1'b1;
         end
         FLASH: begin
            ns_yellow = flash_bit;
            ew_red    = flash_bit;
         end
         default: begin
            ns_red = 1'b1;
            ew_red = 1'b1;
         end
      endcase
   end

endmodule
